// File: rtl/jtag_master.sv
`default_nettype none
// jtag_master: command-driven JTAG master that issues TLR sequences and IR/DR scans to a TAP.
// Define JTAG_MASTER_CMD_RESET_EN to honour cmd_reset as a TLR command. Rev 1.0
module jtag_master #(
  parameter int REGISTER_SIZE = 32,
  parameter int IR_SIZE       = 4,
  parameter int CLK_DIV       = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_ir,
  input  logic                           cmd_reset,
  input  logic [$clog2(REGISTER_SIZE):0] cmd_len,
  input  logic [REGISTER_SIZE-1:0]       cmd_data,
  output logic                           rsp_valid,
  output logic [REGISTER_SIZE-1:0]       rsp_data,
  output logic                           tck,
  output logic                           tms,
  output logic                           tdi,
  input  logic                           tdo
);

  localparam int LW = $clog2(REGISTER_SIZE) + 1;
  localparam int IW = (LW > 1) ? LW - 1 : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [LW-1:0] REG_LEN = LW'(REGISTER_SIZE);
  localparam logic [LW-1:0] IR_LEN  = LW'(IR_SIZE);
  localparam logic [LW-1:0] TLR_LEN = LW'(6);

  typedef enum logic [2:0] {
    TLR_SEQ, IDLE, SELECT, SHIFT, EXIT_UPDATE, RETURN, DONE
  } state_t;

  state_t                   state;
  logic [DW-1:0]            div;
  logic [LW-1:0]            cnt;
  logic [LW-1:0]            len;
  logic [REGISTER_SIZE-1:0] data;
  logic                     is_ir;
  logic                     tlr_cmd;

  logic                     running;
  logic                     tick;
  logic                     rise;
  logic                     fall;
  logic [LW-1:0]            nxt;
  logic [LW-1:0]            sel_len;
  logic [LW-1:0]            eff_len;
  logic [REGISTER_SIZE-1:0] ir_data;
  logic                     do_tlr;

  assign running = (state != IDLE) && (state != DONE);
  assign tick    = (div == DIV_MAX);
  assign rise    = running && tick && !tck;
  assign fall    = running && tick && tck;
  assign nxt     = cnt + LW'(1);
  // IR path passes through Select-IR, so it needs one extra TMS=1 cycle.
  assign sel_len = is_ir ? LW'(4) : LW'(3);
  assign eff_len = ((cmd_len == '0) || (cmd_len > REG_LEN)) ? REG_LEN : cmd_len;

  always_comb begin
    ir_data = '0;
    for (int i = 0; i < REGISTER_SIZE; i++) begin
      if (i < IR_SIZE) ir_data[i] = cmd_data[i];
    end
  end

`ifdef JTAG_MASTER_CMD_RESET_EN
  assign do_tlr = cmd_reset;
`else
  logic unused_cmd_reset;
  assign unused_cmd_reset = cmd_reset;
  assign do_tlr = 1'b0;
`endif

  // TMS/TDI are only updated on the CLK that drops TCK; TDO is taken on the CLK that raises it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TLR_SEQ;
      div       <= '0;
      cnt       <= '0;
      len       <= '0;
      data      <= '0;
      is_ir     <= 1'b0;
      tlr_cmd   <= 1'b1;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (running) begin
        if (tick) begin
          div <= '0;
          tck <= ~tck;
        end else begin
          div <= div + DW'(1);
        end
      end
      if (rise && (state == SHIFT)) rsp_data[cnt[IW-1:0]] <= tdo;

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            rsp_data  <= '0;
            cnt       <= '0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            tlr_cmd   <= do_tlr;
            is_ir     <= cmd_ir;
            len       <= cmd_ir ? IR_LEN : eff_len;
            data      <= cmd_ir ? ir_data : cmd_data;
            state     <= do_tlr ? TLR_SEQ : SELECT;
          end
        end
        TLR_SEQ: begin
          if (fall) begin
            if (nxt < TLR_LEN) begin
              cnt <= nxt;
              tms <= (nxt < LW'(5));
            end else begin
              cnt   <= '0;
              state <= DONE;
            end
          end
        end
        SELECT: begin
          if (fall) begin
            if (nxt < sel_len) begin
              cnt <= nxt;
              tms <= (nxt < (sel_len - LW'(2)));
            end else begin
              cnt   <= '0;
              tms   <= (len == LW'(1));
              tdi   <= data[0];
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (fall) begin
            if (nxt < len) begin
              cnt <= nxt;
              tms <= (nxt == (len - LW'(1)));
              tdi <= data[nxt[IW-1:0]];
            end else begin
              cnt   <= '0;
              tms   <= 1'b1;
              tdi   <= 1'b0;
              state <= EXIT_UPDATE;
            end
          end
        end
        EXIT_UPDATE: begin
          if (fall) begin
            tms   <= 1'b0;
            state <= RETURN;
          end
        end
        RETURN: begin
          if (fall) state <= DONE;
        end
        DONE: begin
          cmd_ready <= 1'b1;
          rsp_valid <= ~tlr_cmd;
          state     <= IDLE;
        end
        default: state <= TLR_SEQ;
      endcase
    end
  end

endmodule
`default_nettype wire
